key_event_decoder: RTL
======================

# key_event_decoder

Receive-side counterpart of the push-button instruction injector. Watches the injected instruction bus (`insn_key`) and its activity window (`key_pressed_out`), and decodes each press window's jump instruction back into a 2-bit key event code. Events are buffered in a small FIFO and handed to game logic over a valid/ready handshake, so game-state code sees each button press exactly once and never has to parse instruction words.

## Interface
Parameters:
- `FIFO_DEPTH`, default 4: event FIFO entries; power of two, at least 2.
- `ADDR_KEY3`, default 27'd90: jump target that encodes KEY3.
- `ADDR_KEY2`, default 27'd82: jump target that encodes KEY2.
- `ADDR_KEY1`, default 27'd98: jump target that encodes KEY1.

Ports:
- `clk_in`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `insn_key`  in  32  injected instruction word, sampled every cycle.
- `key_pressed_out`  in  1  press window from the injector; high for a contiguous run of cycles per press.
- `event_ready`  in  1  consumer accepts the head event this cycle.
- `event_valid`  out  1  FIFO non-empty.
- `event_code`  out  2  head event: 2'd3 = KEY3, 2'd2 = KEY2, 2'd1 = KEY1. 2'd0 is never emitted.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- `overflow`  out  1  sticky; set when an event is dropped because the FIFO is full.
- `bad_window`  out  1  one-cycle pulse; a press window closed with no recognised instruction.

## Operation
- Decode rule (combinational): recognised when `insn_key[31:27]` == 5'b00001 and `insn_key[26:0]` equals one of the three ADDR parameters.
  - Map: ADDR_KEY3 → 3, ADDR_KEY2 → 2, ADDR_KEY1 → 1.
  - An all-zero word (nop) and any other word are not recognised.
- Window FSM, three states:
  - IDLE: when `key_pressed_out`=1, go to OPEN. If a recognised word is present that same cycle, push it and go to DONE instead.
  - OPEN: on a recognised word, push it and go to DONE. If `key_pressed_out` is 0 and nothing was captured, pulse `bad_window` and go to IDLE.
  - DONE: ignore all further words. When `key_pressed_out`=0, go to IDLE.
- At most one event is pushed per window. A window is a maximal run of `key_pressed_out`=1.
- Recognised words seen while in IDLE with `key_pressed_out`=0 are ignored.
- FIFO push/pop:
  - pop = `event_valid & event_ready`.
  - push when full and no pop: the event is dropped and `overflow` is set.
  - push when full with pop in the same cycle: accepted; count stays at FIFO_DEPTH.
  - push and pop on an empty FIFO: no bypass. The push lands and count becomes 1.
- `overflow` is cleared only by `reset`.

## Timing
- Reset values: FSM = IDLE, FIFO empty, `event_valid`=0, `event_code`=0, `fifo_count`=0, `overflow`=0, `bad_window`=0.
- Reset overrides any push or pop in the same cycle.
- Reset in mid-window returns the FSM to IDLE. If `key_pressed_out` is still high after reset, that is treated as a new window.
- Latency: a recognised word sampled at edge N is pushed at edge N. With the FIFO previously empty, `event_valid`=1 and `event_code` are valid from edge N through N+1.
- `event_code` is registered from the FIFO head and holds stable while `event_valid`=1 and `event_ready`=0.
- `bad_window` is high for exactly the one cycle after the edge that sampled window close.
- `fifo_count` updates at the same edge as the push or pop.
- `event_ready` has no effect when `event_valid`=0.

## Test plan
- KEY2 press: `key_pressed_out` high for 3 cycles, `insn_key`=0 in cycles 1-2 and 32'h08000052 in cycle 3 → exactly one event with `event_code`=2, `fifo_count`=1, `bad_window` never high.
- Repeated word: 32'h0800005A held for all 3 window cycles → one event only, code 3. A second window with 32'h08000062 → second event, code 1. Pop both with `event_ready`=1 → codes 3 then 1, `fifo_count` returns to 0.
- Overflow: 5 KEY1 windows with `event_ready`=0 → `fifo_count`=4, `overflow`=1 after the 5th window, and popping returns four code-1 events.
- Bad window: 3-cycle window with `insn_key` alternating 0 and 32'h08000010 → no push, single-cycle `bad_window` after the window closes.
- Full FIFO with simultaneous push and pop: FIFO at 4, `event_ready`=1 on the push cycle → `fifo_count` stays 4, `overflow` stays 0, and the new event is last out.
- Reset mid-window: `reset` asserted during the 2nd cycle of a KEY3 window → outputs at reset values, no event pushed. The window continuing after reset with 32'h0800005A → one code-3 event.

Source files
------------

// File: rtl/key_event_decoder.sv
// rtl/key_event_decoder.sv - decodes injected jump words per press window into buffered key events
module key_event_decoder #(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [26:0] ADDR_KEY3  = 27'd90,
    parameter logic [26:0] ADDR_KEY2  = 27'd82,
    parameter logic [26:0] ADDR_KEY1  = 27'd98
) (
    input  logic                          clk_in,
    input  logic                          reset,
    input  logic [31:0]                   insn_key,
    input  logic                          key_pressed_out,
    input  logic                          event_ready,
    output logic                          event_valid,
    output logic [1:0]                    event_code,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic                          bad_window
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_OPEN = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic          bad_q, bad_d;
    logic          ovf_q, ovf_d;
    logic [1:0]    code_q, code_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] rd_ptr_q, wr_ptr_q, rd_ptr_inc;
    logic [1:0]    mem_q [FIFO_DEPTH];

    logic [1:0]    dec_code;
    logic          recognised;
    logic          push, pop, full, push_ok;

    // Map a jump word back to its key code; anything else decodes to 0.
    always_comb begin
        dec_code = 2'd0;
        if (insn_key[31:27] == 5'b00001) begin
            if (insn_key[26:0] == ADDR_KEY3)      dec_code = 2'd3;
            else if (insn_key[26:0] == ADDR_KEY2) dec_code = 2'd2;
            else if (insn_key[26:0] == ADDR_KEY1) dec_code = 2'd1;
        end
    end

    assign recognised = (dec_code != 2'd0);

    // Window tracker: capture the first recognised word of each press, flag empty presses.
    always_comb begin
        state_d = state_q;
        push    = 1'b0;
        bad_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (key_pressed_out) begin
                    if (recognised) begin
                        push    = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_OPEN;
                    end
                end
            end
            ST_OPEN: begin
                if (key_pressed_out && recognised) begin
                    push    = 1'b1;
                    state_d = ST_DONE;
                end else if (!key_pressed_out) begin
                    bad_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_DONE: begin
                if (!key_pressed_out) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign full       = (count_q == CNT_FULL);
    assign pop        = event_valid & event_ready;
    assign push_ok    = push & (~full | pop);
    assign rd_ptr_inc = rd_ptr_q + AW'(1);

    // Occupancy, sticky overflow and the registered head code as they stand after this edge.
    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q;
        code_d  = code_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
        if (push && full && !pop) ovf_d = 1'b1;
        if (pop) begin
            if (count_q > CNT_ONE) code_d = mem_q[rd_ptr_inc];
            else if (push_ok)      code_d = dec_code;
            else                   code_d = 2'd0;
        end else if (count_q == '0 && push_ok) begin
            code_d = dec_code;
        end
    end

    // Control state; reset wins over any push or pop in the same cycle.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            bad_q    <= 1'b0;
            ovf_q    <= 1'b0;
            code_q   <= 2'd0;
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            state_q <= state_d;
            bad_q   <= bad_d;
            ovf_q   <= ovf_d;
            code_q  <= code_d;
            count_q <= count_d;
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)     rd_ptr_q <= rd_ptr_inc;
        end
    end

    // Event storage; contents are don't-care outside the occupied range.
    always_ff @(posedge clk_in) begin
        if (!reset && push_ok) mem_q[wr_ptr_q] <= dec_code;
    end

    assign event_valid = (count_q != '0);
    assign event_code  = code_q;
    assign fifo_count  = count_q;
    assign overflow    = ovf_q;
    assign bad_window  = bad_q;

endmodule
